vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
Transaction controller that sequences the vending machine datapath. It accumulates credit from nickel/dime pulses and validates an item selection against its price. It then issues a single dispense pulse and pays out change or refunds as spaced nickel_out pulses. It sits between the ui_in coin/select pins and the uo_out dispense/nickel_out pins, and owns all credit state.

Parameters:
CREDIT_W, 6, credit counter width in nickels (max credit = 2^CREDIT_W-1 = 63 nickels).
PAYOUT_GAP, 4, cycles between successive nickel_out pulses (>=2).

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
item_number  input  4  item code, sampled only with select; price = item_number+1 nickels (1..16).
select  input  1  one-cycle request to purchase item_number.
cancel  input  1  one-cycle request to refund all credit.
nickel_in  input  1  one-cycle pulse, +1 nickel.
dime_in  input  1  one-cycle pulse, +2 nickels.
dispense  output  1  one-cycle pulse, item released.
nickel_out  output  1  one-cycle pulse, one nickel returned.
coin_reject  output  1  one-cycle pulse, coin(s) this cycle not credited.
insufficient  output  1  one-cycle pulse, select refused (credit < price).
busy  output  1  high in VEND and PAYOUT.
credit  output  CREDIT_W  current credit in nickels.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, credit=0, gap counter=0. All outputs 0. Reset mid-payout abandons the remaining change with no further nickel_out.
- All outputs are registered. A pulse output responds to an event sampled at edge N by going high during cycle N+1 for exactly one cycle.
- States: IDLE (credit==0), CREDIT (credit>0, accepting), VEND, PAYOUT.
- Coin add in IDLE/CREDIT: add = nickel_in + 2*dime_in (both together = +3).
  - If credit+add > 2^CREDIT_W-1, add nothing and pulse coin_reject.
  - A successful add with credit>0 -> CREDIT.
- Coins in VEND/PAYOUT are never credited; pulse coin_reject.
- select in IDLE/CREDIT is compared against the registered credit, excluding coins sampled the same edge.
  - credit >= price: -> VEND. Coins on that same edge are rejected (coin_reject).
  - credit < price: pulse insufficient, state unchanged. Same-edge coins are credited normally.
- Priority in IDLE/CREDIT: cancel > select > coin.
  - cancel with credit>0 -> PAYOUT; same-edge coins are rejected.
  - cancel with credit==0 is a no-op.
- VEND lasts exactly 1 cycle:
  - dispense=1, credit <= credit-price, gap counter=0.
  - Next state: PAYOUT if the remaining credit > 0, else IDLE.
- PAYOUT:
  - Each cycle with gap==0 and credit>0: nickel_out pulses next cycle, credit decrements, gap <= PAYOUT_GAP-1.
  - Otherwise gap decrements.
  - When credit reaches 0 -> IDLE. busy drops the cycle after the final nickel_out pulse.
  - select/cancel ignored (no insufficient pulse).
- nickel_out pulses are spaced exactly PAYOUT_GAP cycles apart, first pulse 1 cycle after PAYOUT entry.
- credit never wraps. It only decrements by price (VEND) or 1 (PAYOUT).

Test Plan:
- Reset then idle 10 cycles -> every output 0, credit=0, state IDLE.
- dime, dime, nickel (credit=5); select item 3 (price 4) -> dispense single pulse; then exactly 1 nickel_out; credit=0; busy low after payout.
- nickel (credit=1); select item 5 (price 6) -> insufficient pulse, no dispense, credit stays 1.
- credit 7 via coins; cancel -> 7 nickel_out pulses exactly 4 cycles apart, no dispense; dime during payout -> coin_reject, credit unchanged.
- Credit 62, then nickel+dime same cycle -> coin_reject, credit 62; then nickel -> credit 63; then nickel -> coin_reject.
- select+cancel same cycle with credit 10 -> cancel wins, 10 nickel_out, no dispense. Assert reset after the 3rd nickel_out -> no further pulses, credit=0.

Source files
------------

// File: rtl/vend_sequencer.sv
// vend_sequencer: transaction controller for the vending machine datapath.
//
// It accumulates credit in nickels from coin pulses and checks an item selection
// against its price (item_number + 1 nickels). On a successful purchase it issues one
// dispense pulse and then pays out any change as nickel_out pulses spaced PAYOUT_GAP
// cycles apart. A cancel refunds all credit the same way. All outputs are registered:
// an event sampled at edge N shows up during cycle N+1.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   item_number  item code, sampled only with select
//   select       one-cycle purchase request
//   cancel       one-cycle refund request
//   nickel_in    one-cycle pulse, +1 nickel
//   dime_in      one-cycle pulse, +2 nickels
//   dispense     one-cycle pulse, item released
//   nickel_out   one-cycle pulse, one nickel returned
//   coin_reject  one-cycle pulse, coin(s) of this event not credited
//   insufficient one-cycle pulse, select refused (credit < price)
//   busy         high while vending or paying out
//   credit       current credit in nickels
module vend_sequencer #(
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned PAYOUT_GAP = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          item_number,
  input  logic                select,
  input  logic                cancel,
  input  logic                nickel_in,
  input  logic                dime_in,
  output logic                dispense,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned SumW = CREDIT_W + 1;
  localparam int unsigned GapW = (PAYOUT_GAP > 2) ? $clog2(PAYOUT_GAP) : 1;
  localparam logic [GapW-1:0] GapReload = GapW'(PAYOUT_GAP - 1);
  localparam logic [SumW-1:0] CreditMax = {1'b0, {CREDIT_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StCredit, StVend, StPayout} state_e;

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] price_q;
  logic [GapW-1:0]     gap_q;
  logic                dispense_q;
  logic                nickel_out_q;
  logic                coin_reject_q;
  logic                insufficient_q;
  logic                busy_q;

  logic            coin_any;
  logic            coin_fits;
  logic            credit_ok;
  logic [4:0]      price5;
  logic [SumW-1:0] price_ext;
  logic [SumW-1:0] credit_sum;

  // Sums are one bit wider than credit so overflow is visible before it is committed.
  always_comb begin
    coin_any   = nickel_in | dime_in;
    credit_sum = {1'b0, credit_q} + SumW'({dime_in, nickel_in});
    coin_fits  = (credit_sum <= CreditMax);
    price5     = {1'b0, item_number} + 5'd1;
    price_ext  = SumW'(price5);
    credit_ok  = ({1'b0, credit_q} >= price_ext);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      price_q        <= '0;
      gap_q          <= '0;
      dispense_q     <= 1'b0;
      nickel_out_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      dispense_q     <= 1'b0;
      nickel_out_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;

      unique case (state_q)
        StIdle, StCredit: begin
          busy_q <= 1'b0;
          if (cancel && (credit_q != '0)) begin
            state_q       <= StPayout;
            gap_q         <= '0;
            busy_q        <= 1'b1;
            coin_reject_q <= coin_any;
          end else if (select && credit_ok) begin
            // Price is judged against registered credit; same-edge coins are refused.
            state_q       <= StVend;
            price_q       <= price_ext[CREDIT_W-1:0];
            dispense_q    <= 1'b1;
            busy_q        <= 1'b1;
            coin_reject_q <= coin_any;
          end else begin
            insufficient_q <= select;
            if (coin_any) begin
              if (coin_fits) begin
                credit_q <= credit_sum[CREDIT_W-1:0];
                state_q  <= StCredit;
              end else begin
                coin_reject_q <= 1'b1;
              end
            end
          end
        end

        StVend: begin
          coin_reject_q <= coin_any;
          credit_q      <= credit_q - price_q;
          gap_q         <= '0;
          if (credit_q == price_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StPayout;
            busy_q  <= 1'b1;
          end
        end

        StPayout: begin
          coin_reject_q <= coin_any;
          if (credit_q == '0) begin
            // Leave one cycle after the last nickel so busy covers that pulse.
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (gap_q == '0) begin
            nickel_out_q <= 1'b1;
            credit_q     <= credit_q - CREDIT_W'(1);
            gap_q        <= GapReload;
          end else begin
            gap_q <= gap_q - GapW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dispense     = dispense_q;
  assign nickel_out   = nickel_out_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign busy         = busy_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, so each check sees the result of
// the edge just taken.
module tb_vend_sequencer;

  logic       clock;
  logic       reset;
  logic [3:0] item_number;
  logic       select;
  logic       cancel;
  logic       nickel_in;
  logic       dime_in;
  logic       dispense;
  logic       nickel_out;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;
  logic [5:0] credit;

  int checks = 0;
  int errors = 0;

  vend_sequencer #(
    .CREDIT_W  (6),
    .PAYOUT_GAP(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .item_number (item_number),
    .select      (select),
    .cancel      (cancel),
    .nickel_in   (nickel_in),
    .dime_in     (dime_in),
    .dispense    (dispense),
    .nickel_out  (nickel_out),
    .coin_reject (coin_reject),
    .insufficient(insufficient),
    .busy        (busy),
    .credit      (credit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic coin(input logic n, input logic d);
    nickel_in = n;
    dime_in   = d;
    tick();
    nickel_in = 1'b0;
    dime_in   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({dispense, nickel_out, coin_reject, insufficient, busy} !== 5'b0 || credit !== 6'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outs=%b credit=%0d, want outs=00000 credit=0", i,
                 {dispense, nickel_out, coin_reject, insufficient, busy}, credit);
      end
    end
  endtask

  task automatic test_vend();
    do_reset();
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    checks++;
    if (credit !== 6'd5) begin
      errors++;
      $display("FAIL vend_credit got %0d want 5", credit);
    end
    // Select item 3 (price 4) with a nickel on the same edge: nickel must be refused.
    item_number = 4'd3;
    select      = 1'b1;
    nickel_in   = 1'b1;
    tick();
    select    = 1'b0;
    nickel_in = 1'b0;
    checks++;
    if ({dispense, coin_reject, busy} !== 3'b111 || credit !== 6'd5) begin
      errors++;
      $display("FAIL vend_select got disp/rej/busy=%b credit=%0d want 111 credit=5",
               {dispense, coin_reject, busy}, credit);
    end
    tick();
    checks++;
    if ({dispense, nickel_out, busy} !== 3'b001 || credit !== 6'd1) begin
      errors++;
      $display("FAIL vend_deduct got disp/nout/busy=%b credit=%0d want 001 credit=1",
               {dispense, nickel_out, busy}, credit);
    end
    tick();
    checks++;
    if ({nickel_out, busy} !== 2'b11 || credit !== 6'd0) begin
      errors++;
      $display("FAIL vend_change got nout/busy=%b credit=%0d want 11 credit=0",
               {nickel_out, busy}, credit);
    end
    tick();
    checks++;
    if ({dispense, nickel_out, busy} !== 3'b000 || credit !== 6'd0) begin
      errors++;
      $display("FAIL vend_done got disp/nout/busy=%b credit=%0d want 000 credit=0",
               {dispense, nickel_out, busy}, credit);
    end
    begin
      int extra = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (nickel_out || dispense) extra++;
      end
      checks++;
      if (extra !== 0) begin
        errors++;
        $display("FAIL vend_quiet got %0d stray pulses want 0", extra);
      end
    end
  endtask

  task automatic test_insufficient();
    do_reset();
    coin(1'b1, 1'b0);
    item_number = 4'd5;
    select      = 1'b1;
    tick();
    select = 1'b0;
    checks++;
    if ({insufficient, dispense, busy} !== 3'b100 || credit !== 6'd1) begin
      errors++;
      $display("FAIL insuff_pulse got ins/disp/busy=%b credit=%0d want 100 credit=1",
               {insufficient, dispense, busy}, credit);
    end
    tick();
    checks++;
    if ({insufficient, dispense} !== 2'b00 || credit !== 6'd1) begin
      errors++;
      $display("FAIL insuff_after got ins/disp=%b credit=%0d want 00 credit=1",
               {insufficient, dispense}, credit);
    end
    // Refused select still credits a same-edge dime: 1 + 2 = 3.
    select  = 1'b1;
    dime_in = 1'b1;
    tick();
    select  = 1'b0;
    dime_in = 1'b0;
    checks++;
    if ({insufficient, coin_reject, dispense} !== 3'b100 || credit !== 6'd3) begin
      errors++;
      $display("FAIL insuff_coin got ins/rej/disp=%b credit=%0d want 100 credit=3",
               {insufficient, coin_reject, dispense}, credit);
    end
  endtask

  task automatic test_cancel();
    int idx[$];
    int disp;
    logic bad_gap;
    disp    = 0;
    bad_gap = 1'b0;
    do_reset();
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if ({busy, nickel_out, dispense} !== 3'b100 || credit !== 6'd7) begin
      errors++;
      $display("FAIL cancel_entry got busy/nout/disp=%b credit=%0d want 100 credit=7",
               {busy, nickel_out, dispense}, credit);
    end
    for (int i = 1; i <= 40; i++) begin
      if (i == 2) dime_in = 1'b1;
      tick();
      dime_in = 1'b0;
      if (nickel_out) idx.push_back(i);
      if (dispense) disp++;
      if (i == 2) begin
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd6) begin
          errors++;
          $display("FAIL cancel_coin_reject got rej=%b credit=%0d want rej=1 credit=6",
                   coin_reject, credit);
        end
      end
      if (i == 25) begin
        checks++;
        if ({nickel_out, busy} !== 2'b11) begin
          errors++;
          $display("FAIL cancel_last_pulse got nout/busy=%b want 11", {nickel_out, busy});
        end
      end
      if (i == 26) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL cancel_busy_drop got %b want 0", busy);
        end
      end
    end
    checks++;
    if (idx.size() !== 7) begin
      errors++;
      $display("FAIL cancel_count got %0d want 7", idx.size());
    end
    for (int k = 1; k < idx.size(); k++) if (idx[k] - idx[k-1] != 4) bad_gap = 1'b1;
    checks++;
    if (idx.size() == 0 || idx[0] != 1 || bad_gap) begin
      errors++;
      $display("FAIL cancel_spacing got first=%0d bad_gap=%b want first=1 gap=4",
               (idx.size() > 0) ? idx[0] : -1, bad_gap);
    end
    checks++;
    if (disp !== 0 || credit !== 6'd0) begin
      errors++;
      $display("FAIL cancel_end got dispenses=%0d credit=%0d want 0 0", disp, credit);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 31; i++) coin(1'b0, 1'b1);
    checks++;
    if (credit !== 6'd62) begin
      errors++;
      $display("FAIL ovf_build got %0d want 62", credit);
    end
    coin(1'b1, 1'b1);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 6'd62) begin
      errors++;
      $display("FAIL ovf_both got rej=%b credit=%0d want rej=1 credit=62", coin_reject, credit);
    end
    coin(1'b1, 1'b0);
    checks++;
    if (coin_reject !== 1'b0 || credit !== 6'd63) begin
      errors++;
      $display("FAIL ovf_fill got rej=%b credit=%0d want rej=0 credit=63", coin_reject, credit);
    end
    coin(1'b1, 1'b0);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 6'd63) begin
      errors++;
      $display("FAIL ovf_full got rej=%b credit=%0d want rej=1 credit=63", coin_reject, credit);
    end
  endtask

  task automatic test_select_cancel_reset();
    int nick;
    int disp;
    int stray;
    nick  = 0;
    disp  = 0;
    stray = 0;
    do_reset();
    for (int i = 0; i < 5; i++) coin(1'b0, 1'b1);
    item_number = 4'd0;
    select      = 1'b1;
    cancel      = 1'b1;
    tick();
    select = 1'b0;
    cancel = 1'b0;
    checks++;
    if ({busy, dispense, insufficient} !== 3'b100 || credit !== 6'd10) begin
      errors++;
      $display("FAIL selcan_entry got busy/disp/ins=%b credit=%0d want 100 credit=10",
               {busy, dispense, insufficient}, credit);
    end
    for (int i = 1; i <= 30 && nick < 3; i++) begin
      tick();
      if (nickel_out) nick++;
      if (dispense) disp++;
    end
    checks++;
    if (nick !== 3 || disp !== 0 || credit !== 6'd7) begin
      errors++;
      $display("FAIL selcan_three got nickels=%0d disp=%0d credit=%0d want 3 0 7", nick, disp,
               credit);
    end
    do_reset();
    checks++;
    if ({dispense, nickel_out, coin_reject, insufficient, busy} !== 5'b0 || credit !== 6'd0) begin
      errors++;
      $display("FAIL selcan_reset got outs=%b credit=%0d want 00000 credit=0",
               {dispense, nickel_out, coin_reject, insufficient, busy}, credit);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (nickel_out || dispense || busy || credit != 6'd0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL selcan_abandon got %0d active cycles want 0", stray);
    end
  endtask

  initial begin
    reset       = 1'b1;
    item_number = 4'd0;
    select      = 1'b0;
    cancel      = 1'b0;
    nickel_in   = 1'b0;
    dime_in     = 1'b0;
    test_reset();
    test_vend();
    test_insufficient();
    test_cancel();
    test_overflow();
    test_select_cancel_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
